// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 multiplier.
// Holds the FSM state enum, operand/product widths and the magnitude helper.
package mul_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement magnitude when signed; the most negative value maps
    // onto itself, which is its correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(
        input logic [DATA_W-1:0] x,
        input logic              s
    );
        return (s && x[DATA_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/multiplier_iterative_step.sv
// Combinational radix-4 step: acc_next = acc + b * a_sh, b in 0..3.
// Ports: acc, a_sh (PROD_W), b (2 bits) in; acc_next (PROD_W) out.
module mul_radix4_step
    import mul_pkg::*;
(
    input  logic [PROD_W-1:0] acc,
    input  logic [PROD_W-1:0] a_sh,
    input  logic [1:0]        b,
    output logic [PROD_W-1:0] acc_next
);

    logic [PROD_W-1:0] pp;

    always_comb begin
        pp = '0;
        unique case (b)
            2'd0: pp = '0;
            2'd1: pp = a_sh;
            2'd2: pp = a_sh << 1;
            2'd3: pp = a_sh + (a_sh << 1);
        endcase
        acc_next = acc + pp;
    end

endmodule

// File: rtl/multiplier_iterative.sv
// Multi-cycle 32x32->64 multiplier (radix-4 shift-add, sign-magnitude).
// Ports: clk, reset (sync, active-high), stall, flush, start, signed_op,
//   multiplicand, multiplier in; busy, done, product_hi, product_lo out.
// Option: MUL_EARLY_OUT_EN finishes once the remaining multiplier is zero.
module multiplier_iterative
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product_hi,
    output logic [DATA_W-1:0] product_lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] a_sh;
    logic [PROD_W-1:0] acc_next;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] result;
    logic [DATA_W-1:0] b;
    logic              neg;
    logic              last;

    mul_radix4_step u_step (
        .acc      (acc),
        .a_sh     (a_sh),
        .b        (b[1:0]),
        .acc_next (acc_next)
    );

`ifdef MUL_EARLY_OUT_EN
    // Finish on the step that retires the last non-zero multiplier digit.
    assign last = (cnt == CNT_LAST) || (b[DATA_W-1:2] == '0);
`else
    assign last = (cnt == CNT_LAST);
`endif

    assign result = neg ? -acc_next : acc_next;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b     <= '0;
            neg   <= 1'b0;
            prod  <= '0;
        end else if (!stall) begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= {{DATA_W{1'b0}}, mag(multiplicand, signed_op)};
                        b    <= mag(multiplier, signed_op);
                        neg  <= signed_op & (multiplicand[DATA_W-1]
                                             ^ multiplier[DATA_W-1]);
                        acc  <= '0;
                        cnt  <= '0;
                        prod <= '0;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 2;
                    b    <= b >> 2;
                    cnt  <= cnt + 1'b1;
                    if (last) prod <= result;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign product_hi = prod[PROD_W-1:DATA_W];
    assign product_lo = prod[DATA_W-1:0];

endmodule

// File: tb/tb_multiplier_iterative.sv
// Self-checking bench for multiplier_iterative.
// Random and directed operands against an arithmetic reference model.
module tb_multiplier_iterative;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        start;
    logic        signed_op;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int checks = 0;
    int errors = 0;

    multiplier_iterative dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .start        (start),
        .signed_op    (signed_op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (s) return 64'(sa * sb);
        return ua * ub;
    endfunction

    // Cycles from the start edge to the first cycle with done high.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] m;
        int          d;
        m = (s && b[31]) ? -b : b;
        d = 1;
        while (d < 16 && (m >> (2 * d)) != 0) d++;
        return d + 1;
`else
        if (s === 1'bx) return 0;
        return 17 + 0 * int'(b[0]);
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int sa, input int sl,
                          input bit poke);
        logic [63:0] exp;
        int          lat;
        int          k;
        bit          seen;
        bit          out;
        exp = model(a, b, s);
        lat = exp_lat(b, s);
        if (sa > 0 && sa < lat) lat += sl;
        multiplicand = a;
        multiplier   = b;
        signed_op    = s;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_calc", 64'(busy), 64'd1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            k++;
            stall = (k >= sa && k < sa + sl);
            if (poke) begin
                start = (k == 4);
                if (k == 4) begin
                    multiplicand = $urandom;
                    multiplier   = $urandom;
                    signed_op    = ~s;
                end
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) begin
                chk("busy_drop", 64'(busy), 64'd1);
                k = 60;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("latency", 64'(k + 1), 64'(lat));
            chk("busy_done", 64'(busy), 64'd1);
            chk("product", {product_hi, product_lo}, exp);
            out = 1'b0;
            while (!out && k < 80) begin
                k++;
                stall = (k >= sa && k < sa + sl);
                @(posedge clk);
                @(negedge clk);
                if (stall) begin
                    chk("done_hold", 64'(done), 64'd1);
                end else begin
                    chk("done_clear", 64'(done), 64'd0);
                    chk("busy_clear", 64'(busy), 64'd0);
                    chk("product_hold", {product_hi, product_lo}, exp);
                    out = 1'b1;
                end
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corner [5];
        logic [31:0] ra;
        logic [31:0] rb;
        int          dn;
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        reset        = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        start        = 1'b0;
        signed_op    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {product_hi, product_lo}, 64'd0);
        reset = 1'b0;

        run_op(32'd7, 32'd9, 1'b0, 0, 0, 1'b0);
        chk("u7x9_lo", 64'(product_lo), 64'h3F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
        chk("umax_hi", 64'(product_hi), 64'hFFFF_FFFE);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);
        chk("s_m1_lo", 64'(product_lo), 64'h1);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, 1'b0);
        chk("s_m3x5_lo", 64'(product_lo), 64'hFFFF_FFF1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 1'b0);
        chk("s_min_hi", 64'(product_hi), 64'h4000_0000);

        run_op(32'd7, 32'd9, 1'b0, 5, 3, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd7, 1'b1,
               exp_lat(32'd7, 1'b1), 3, 1'b0);
        run_op(32'd123456, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b1);
        run_op(32'd5, 32'd0, 1'b0, 0, 0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("start_flush", 64'(busy), 64'd0);

        multiplicand = 32'h1234_5678;
        multiplier   = 32'hFFFF_FFFF;
        signed_op    = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_prod", {product_hi, product_lo}, 64'd0);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("flush_nodone", 64'(dn), 64'd0);
        run_op(32'd2, 32'd3, 1'b0, 0, 0, 1'b0);
        chk("after_flush", 64'(product_lo), 64'd6);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)]
                                              : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)]
                                              : $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
